// File: rtl/alu_frame_tx.sv
// Serial frame transmitter for the ALU serial input: computes CRC4 over {B,A,1,OP},
// then shifts out 11-bit data words and the command word on sout (idle high).
module alu_frame_tx #(
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 4,
  parameter int GAP_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [2:0]        in_op,
  input  logic [LEN_W-1:0]  in_len,
  input  logic [3:0]        in_crc_mask,
  output logic              sout,
  output logic              busy,
  output logic              done,
  output logic [3:0]        crc_sent
);

  localparam int AB_W    = 2 * DATA_W;
  localparam int CRC_CYC = AB_W + 4;
  localparam int MAXC    = (CRC_CYC > GAP_CYC) ? CRC_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {IDLE, CRC, DATA, CMD, GAP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         bcnt;
  logic [LEN_W-1:0]   wcnt;
  logic [LEN_W-1:0]   len_r;
  logic [2:0]         op_r;
  logic [3:0]         mask_r;
  logic [CRC_CYC-1:0] msg;
  logic [AB_W-1:0]    dsr;
  logic [10:0]        wsr;
  logic [3:0]         crc;
  logic [3:0]         crc_nxt;
  logic               fb;
  logic [10:0]        data_word;
  logic [10:0]        cmd_first;
  logic [10:0]        cmd_later;

  assign in_ready = (state == IDLE);

  always_comb begin
    fb        = crc[3] ^ msg[CRC_CYC-1];
    crc_nxt   = {crc[2:0], 1'b0} ^ {2'b00, fb, fb};
    data_word = {2'b00, dsr[AB_W-1 -: 8], 1'b1};
    cmd_first = {3'b010, op_r, crc_nxt ^ mask_r, 1'b1};
    cmd_later = {3'b010, op_r, crc_sent, 1'b1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bcnt     <= '0;
      wcnt     <= '0;
      len_r    <= '0;
      op_r     <= '0;
      mask_r   <= '0;
      msg      <= '0;
      dsr      <= '0;
      wsr      <= '1;
      crc      <= '0;
      sout     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      crc_sent <= '0;
    end else begin
      case (state)
        IDLE: begin
          sout <= 1'b1;
          if (in_valid) begin
            state  <= CRC;
            busy   <= 1'b1;
            msg    <= {in_b, in_a, 1'b1, in_op};
            dsr    <= {in_b, in_a};
            len_r  <= in_len;
            op_r   <= in_op;
            mask_r <= in_crc_mask;
            crc    <= '0;
            cnt    <= '0;
          end
        end
        CRC: begin
          crc <= crc_nxt;
          msg <= msg << 1;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(CRC_CYC - 1)) begin
            crc_sent <= crc_nxt ^ mask_r;
            bcnt     <= '0;
            wcnt     <= '0;
            sout     <= 1'b0;
            if (len_r != '0) begin
              state <= DATA;
              wsr   <= data_word;
              dsr   <= dsr << 8;
            end else begin
              state <= CMD;
              wsr   <= cmd_first;
            end
          end
        end
        DATA: begin
          // Zero-filling shift of {B,A} yields 8'h00 pad bytes past NB for free.
          if (bcnt == 4'd10) begin
            bcnt <= '0;
            sout <= 1'b0;
            if (wcnt == len_r - LEN_W'(1)) begin
              state <= CMD;
              wsr   <= cmd_later;
            end else begin
              wcnt <= wcnt + LEN_W'(1);
              wsr  <= data_word;
              dsr  <= dsr << 8;
            end
          end else begin
            bcnt <= bcnt + 4'd1;
            sout <= wsr[9];
            wsr  <= wsr << 1;
          end
        end
        CMD: begin
          if (bcnt == 4'd10) begin
            done <= 1'b0;
            sout <= 1'b1;
            cnt  <= '0;
            if (GAP_CYC == 0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= GAP;
            end
          end else begin
            bcnt <= bcnt + 4'd1;
            sout <= wsr[9];
            wsr  <= wsr << 1;
            done <= (bcnt == 4'd9);
          end
        end
        GAP: begin
          sout <= 1'b1;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(GAP_CYC - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          sout  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_frame_tx.sv
// Self-checking bench for alu_frame_tx: directed and random frames against a
// polynomial-division CRC and a queue-built expected bit stream.
module tb_alu_frame_tx;

  localparam int DATA_W  = 32;
  localparam int LEN_W   = 4;
  localparam int GAP_CYC = 2;
  localparam int NB      = 2 * DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [2:0]        in_op;
  logic [LEN_W-1:0]  in_len;
  logic [3:0]        in_crc_mask;
  logic              sout;
  logic              busy;
  logic              done;
  logic [3:0]        crc_sent;

  int checks = 0;
  int fails  = 0;
  int fno    = 0;

  alu_frame_tx #(.DATA_W(DATA_W), .LEN_W(LEN_W), .GAP_CYC(GAP_CYC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_len(in_len),
    .in_crc_mask(in_crc_mask), .sout(sout), .busy(busy), .done(done),
    .crc_sent(crc_sent)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Remainder of M(x)*x^4 mod (x^4+x+1), M = {B,A,1,OP} MSB first.
  function automatic logic [3:0] ref_crc(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                         input logic [2:0] op);
    logic [2*DATA_W+7:0] m;
    m = {b, a, 1'b1, op, 4'b0000};
    for (int i = 2 * DATA_W + 7; i >= 4; i--)
      if (m[i]) m[i -: 5] = m[i -: 5] ^ 5'b10011;
    return m[3:0];
  endfunction

  task automatic run_frame(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                           input logic [2:0] op, input logic [LEN_W-1:0] len,
                           input logic [3:0] mask, input bit hold, input int abort_at);
    bit              q[$];
    logic [2*DATA_W-1:0] ab;
    logic [7:0]      byte_k;
    logic [3:0]      c;
    logic [10:0]     cmd;
    int              didx;
    int              w;
    logic [3:0]      exp_v;
    fno++;
    ab = {b, a};
    c  = ref_crc(a, b, op) ^ mask;
    repeat (2 * DATA_W + 4) q.push_back(1'b1);
    for (int k = 0; k < int'(len); k++) begin
      byte_k = (k < NB) ? ab[2*DATA_W-1-8*k -: 8] : 8'h00;
      q.push_back(1'b0);
      q.push_back(1'b0);
      for (int j = 7; j >= 0; j--) q.push_back(byte_k[j]);
      q.push_back(1'b1);
    end
    cmd = {3'b010, op, c, 1'b1};
    for (int j = 10; j >= 0; j--) q.push_back(cmd[j]);
    didx = q.size() - 1;
    repeat (GAP_CYC) q.push_back(1'b1);

    w = 0;
    while (!in_ready && w < 400) begin
      @(negedge clk);
      w++;
    end
    check($sformatf("ready_wait%0d", fno), 32'(in_ready), 32'd1);

    in_a = a; in_b = b; in_op = op; in_len = len; in_crc_mask = mask; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = hold;
    in_a = $urandom; in_b = $urandom; in_op = 3'($urandom);
    in_len = LEN_W'($urandom); in_crc_mask = 4'($urandom);

    for (int i = 0; i <= q.size(); i++) begin
      @(negedge clk);
      if (i < q.size()) exp_v = {q[i], (i == didx), 1'b1, 1'b0};
      else              exp_v = 4'b1001;
      check($sformatf("f%0d_cyc%0d_sout_done_busy_rdy", fno, i),
            32'({sout, done, busy, in_ready}), 32'(exp_v));
      if (i == q.size())
        check($sformatf("f%0d_crc_sent", fno), 32'(crc_sent), 32'(c));
      if (i == abort_at) begin
        rst = 1'b1;
        #1;
        check($sformatf("f%0d_async_rst", fno),
              32'({sout, done, busy, in_ready, crc_sent}), 32'({4'b1001, 4'h0}));
        #2;
        rst = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_len = '0; in_crc_mask = '0;
    #1;
    check("reset_state", 32'({sout, done, busy, in_ready, crc_sent}), 32'({4'b1001, 4'h0}));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_frame('0, '0, 3'b000, 4'd8, 4'h0, 1'b0, -1);
    check("crc_zero_const", 32'(crc_sent), 32'hB);
    run_frame('0, '0, 3'b000, 4'd8, 4'h1, 1'b0, -1);
    check("crc_zero_mask1_const", 32'(crc_sent), 32'hA);
    run_frame(32'h04030201, 32'h08070605, 3'b101, 4'd7, 4'h0, 1'b0, -1);
    run_frame(32'h04030201, 32'h08070605, 3'b011, 4'd9, 4'h0, 1'b0, -1);
    run_frame(32'hDEADBEEF, 32'h12345678, 3'b111, 4'd0, 4'h0, 1'b0, -1);
    run_frame(32'hCAFEF00D, 32'h0BADC0DE, 3'b110, 4'd15, 4'h5, 1'b0, -1);

    // Back-to-back frames with in_valid held high throughout.
    run_frame($urandom, $urandom, 3'b001, 4'd8, 4'h0, 1'b1, -1);
    run_frame($urandom, $urandom, 3'b010, 4'd3, 4'h0, 1'b1, -1);
    run_frame($urandom, $urandom, 3'b100, 4'd8, 4'h0, 1'b0, -1);

    // Abort in the middle of data word 3, then a clean frame.
    run_frame(32'h11223344, 32'h55667788, 3'b010, 4'd8, 4'h0, 1'b0, 2 * DATA_W + 4 + 33 + 5);
    @(negedge clk);
    run_frame(32'h11223344, 32'h55667788, 3'b010, 4'd8, 4'h0, 1'b0, -1);

    for (int r = 0; r < 8; r++)
      run_frame($urandom, $urandom, 3'($urandom), LEN_W'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), bit'($urandom_range(0, 1)), -1);
    in_valid = 1'b0;

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
